// File: rtl/lockstep_checker.sv
// Lockstep comparator and halt/recover sequencer for the dual-core CEVERO pair.
// Optional first-error PC log is built only when LOCKSTEP_ERR_LOG_EN is defined.
module lockstep_checker #(
   parameter int DRAIN_CYCLES = 4,
   parameter int MAX_ERRORS   = 10,
   parameter int COUNT_W      = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               instr_req_0_i,
   input  logic               instr_req_1_i,
   input  logic [31:0]        instr_addr_0_i,
   input  logic [31:0]        instr_addr_1_i,
   input  logic               data_req_0_i,
   input  logic               data_req_1_i,
   input  logic               data_we_0_i,
   input  logic               data_we_1_i,
   input  logic [3:0]         data_be_0_i,
   input  logic [3:0]         data_be_1_i,
   input  logic [31:0]        data_addr_0_i,
   input  logic [31:0]        data_addr_1_i,
   input  logic [31:0]        data_wdata_0_i,
   input  logic [31:0]        data_wdata_1_i,
   input  logic [31:0]        pc_id_i,
   input  logic               recovery_done_i,
   output logic               error_o,
   output logic               halt_o,
   output logic               recovery_req_o,
   output logic               fatal_o,
   output logic [COUNT_W-1:0] error_count_o
`ifdef LOCKSTEP_ERR_LOG_EN
  ,output logic [31:0]        err_pc_o
`endif
);

   typedef enum logic [1:0] {RUN, HALT, RECOVER, FATAL} state_e;

   localparam logic [7:0]  DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
   localparam logic [31:0] MAX_U      = 32'(MAX_ERRORS);

   state_e             state_q, state_d;
   logic [7:0]         drain_q, drain_d;
   logic [COUNT_W-1:0] count_q, count_d, count_inc;
   logic               error_q, error_d;
   logic               instr_mm, data_mm, mismatch, hit_max;
   logic [31:0]        wmask;

   // Only write-data lanes that core 0 actually enables are compared.
   always_comb begin
      wmask    = {{8{data_be_0_i[3]}}, {8{data_be_0_i[2]}},
                  {8{data_be_0_i[1]}}, {8{data_be_0_i[0]}}};
      instr_mm = (instr_req_0_i != instr_req_1_i) ||
                 (instr_req_0_i && instr_req_1_i && (instr_addr_0_i != instr_addr_1_i));
      data_mm  = (data_req_0_i != data_req_1_i) ||
                 (data_req_0_i && data_req_1_i &&
                  ((data_we_0_i != data_we_1_i) || (data_be_0_i != data_be_1_i) ||
                   (data_addr_0_i != data_addr_1_i) ||
                   (data_we_0_i && (((data_wdata_0_i ^ data_wdata_1_i) & wmask) != 32'h0))));
      mismatch = instr_mm || data_mm;
   end

   always_comb begin
      count_inc = (count_q == '1) ? count_q : count_q + 1'b1;
      hit_max   = (MAX_ERRORS != 0) && (32'(count_inc) == MAX_U);
   end

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      count_d = count_q;
      error_d = 1'b0;
      case (state_q)
         RUN: begin
            if (mismatch) begin
               error_d = 1'b1;
               count_d = count_inc;
               drain_d = 8'd0;
               state_d = hit_max ? FATAL : HALT;
            end
         end
         HALT: begin
            if (drain_q == DRAIN_LAST) begin
               drain_d = 8'd0;
               state_d = RECOVER;
            end else begin
               drain_d = drain_q + 8'd1;
            end
         end
         RECOVER: begin
            if (recovery_done_i) state_d = RUN;
         end
         FATAL: ;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
         drain_q <= 8'd0;
         count_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         count_q <= count_d;
         error_q <= error_d;
      end
   end

   assign error_o        = error_q;
   assign halt_o         = (state_q != RUN);
   assign recovery_req_o = (state_q == RECOVER);
   assign fatal_o        = (state_q == FATAL);
   assign error_count_o  = count_q;

`ifdef LOCKSTEP_ERR_LOG_EN
   logic [31:0] err_pc_q;

   // The counter never returns to zero except by reset, so zero marks the first error.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_pc_q <= 32'h0;
      end else if ((state_q == RUN) && mismatch && (count_q == '0)) begin
         err_pc_q <= pc_id_i;
      end
   end

   assign err_pc_o = err_pc_q;
`else
   logic unused_pc;
   assign unused_pc = ^pc_id_i;
`endif

endmodule

// File: doc/lockstep_checker.md
# lockstep_checker

Synthesizable detector and recovery sequencer for the dual-core fault-tolerant CEVERO core. It compares the instruction-fetch and data-bus request streams of `core_0` and `core_1` every cycle. On divergence it flags an error, halts both cores, and drives a fixed recovery handshake toward the checkpoint/restore logic. It is the checking end of the fault-injection path: anything injected on core 1's instruction stream must surface here as `error_o`.

## Interface
- `DRAIN_CYCLES`, 4: cycles `halt_o` is held before recovery is requested (1..255).
- `MAX_ERRORS`, 10: number of detected errors that forces FATAL; 0 disables FATAL.
- `COUNT_W`, 8: width of the error counter.

- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `instr_req_0_i` / `instr_req_1_i` in 1: instruction fetch request, core 0 / core 1.
- `instr_addr_0_i` / `instr_addr_1_i` in 32: fetch address.
- `data_req_0_i` / `data_req_1_i` in 1: data request.
- `data_we_0_i` / `data_we_1_i` in 1: write enable.
- `data_be_0_i` / `data_be_1_i` in 4: byte enables.
- `data_addr_0_i` / `data_addr_1_i` in 32: data address.
- `data_wdata_0_i` / `data_wdata_1_i` in 32: write data.
- `pc_id_i` in 32: core 0 ID-stage PC, used for logging.
- `recovery_done_i` in 1: restore logic finished.
- `error_o` out 1: one-cycle pulse per detected error.
- `halt_o` out 1: stall both cores.
- `recovery_req_o` out 1: request restore; level signal, held until acknowledged.
- `fatal_o` out 1: error budget exhausted.
- `error_count_o` out COUNT_W: detected errors, saturating.
- `err_pc_o` out 32: PC at first error. Present only with the log macro.

## Operation
- Mismatch (combinational, evaluated every cycle):
  - Instruction side: `instr_req` differs, OR both requests high and `instr_addr` differs.
  - Data side: `data_req` differs, OR both requests high and any of these differ: `we`, `be`, `addr`, or `wdata` restricted to byte lanes enabled by `data_be_0_i` when `we=1`.
  - No request on either core: never a mismatch.
- FSM states and transitions:
  - RUN: mismatch → HALT (count, pulse).
  - HALT: drain counter counts `DRAIN_CYCLES` cycles, then → RECOVER.
  - RECOVER: `recovery_req_o=1`; `recovery_done_i` sampled high → RUN.
  - FATAL: terminal; only `rst_i` exits.
- Error accounting: `error_count_o` increments by exactly 1 per RUN→HALT transition and saturates at 2^COUNT_W−1.
- FATAL entry: if `MAX_ERRORS`≠0 and the incremented count equals `MAX_ERRORS`, the FSM goes to FATAL instead of HALT. `error_o` still pulses; `halt_o=1` and `fatal_o=1` from then on.
- Mismatches outside RUN are ignored: no count, no pulse.
- `recovery_done_i` is ignored outside RECOVER.
- Reset values: all outputs 0, `err_pc_o`=0, state RUN, drain counter 0.

## Timing
- Mismatch present at cycle N (in RUN) gives, at cycle N+1:
  - `error_o`=1 for one cycle;
  - `halt_o`=1;
  - count updated.
- `halt_o` stays high from N+1 until the cycle after `recovery_done_i` is sampled in RECOVER.
- `recovery_req_o` rises at N+1+`DRAIN_CYCLES` and falls in the same cycle `halt_o` falls.
- `recovery_done_i` high in the first RECOVER cycle → RUN the next cycle. Minimum HALT+RECOVER span: `DRAIN_CYCLES`+1 cycles.
- A mismatch in the first RUN cycle after recovery is detected normally. Back-to-back errors are allowed.
- `rst_i` in any state, including mid-HALT or RECOVER: all outputs clear at the next edge; no pending recovery survives.

## Configuration
- `LOCKSTEP_ERR_LOG_EN` defined:
  - `err_pc_o` exists and captures `pc_id_i` on the first error after reset.
  - It is held through later errors and cleared only by reset.
- `LOCKSTEP_ERR_LOG_EN` undefined:
  - `err_pc_o` port is absent and no capture register is built.
  - All other behaviour is identical.

## Test plan
- Identical streams, fetch 0x0..0xFC, 200 cycles, random data writes → `error_o`, `halt_o` and `error_count_o` stay 0.
- Cycle 50: `instr_addr_1_i`=0x24 vs 0x20, `DRAIN_CYCLES`=4:
  - `error_o` pulse at cycle 51, count=1, `halt_o` high at 51;
  - `recovery_req_o` high at 55;
  - `recovery_done_i` at 58 → `halt_o` and `recovery_req_o` low at 59.
- Write with `be`=0001, `wdata` 0x000000AA vs 0xFF0000AA → no error. Same test with `wdata` 0x000000AB → error.
- `MAX_ERRORS`=3, three separated mismatches with recovery after each → after the third, `fatal_o`=1 and `halt_o`=1 permanently; a later `recovery_done_i` has no effect.
- Mismatch held for 10 cycles continuously → count=1; single pulse.
- Reset mid-RECOVER → all outputs 0 next cycle; `err_pc_o`=0.
- With `LOCKSTEP_ERR_LOG_EN`: first error at `pc_id_i`=0x40, second at 0x60 → `err_pc_o`=0x40.
